// File: rtl/seq_sub64.sv
// Two-cycle W-bit subtractor: low half then high half, borrow carried between them in a register.
// Optional macro SUB_OVF_EN adds a registered signed-overflow output (ovf).
module seq_sub64 #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int HALF = WIDTH / 2;

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic             bin_reg;
  logic             borrow_reg;
  logic [WIDTH-1:0] diff_reg;
  logic             bout_reg;
  logic [HALF:0]    lo_res, hi_res;

  // One extra bit on each slice: a negative result sets it, which is exactly the borrow.
  assign lo_res = {1'b0, a_reg[HALF-1:0]} - {1'b0, b_reg[HALF-1:0]}
                  - {{HALF{1'b0}}, bin_reg};
  assign hi_res = {1'b0, a_reg[WIDTH-1:HALF]} - {1'b0, b_reg[WIDTH-1:HALF]}
                  - {{HALF{1'b0}}, borrow_reg};

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (in_valid) state_next = LOW;
      LOW:  state_next = HIGH;
      HIGH: state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      bin_reg    <= 1'b0;
      borrow_reg <= 1'b0;
      diff_reg   <= '0;
      bout_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: if (in_valid) begin
          a_reg   <= a;
          b_reg   <= b;
          bin_reg <= bin;
        end
        LOW: begin
          diff_reg[HALF-1:0] <= lo_res[HALF-1:0];
          borrow_reg         <= lo_res[HALF];
        end
        HIGH: begin
          diff_reg[WIDTH-1:HALF] <= hi_res[HALF-1:0];
          bout_reg               <= hi_res[HALF];
        end
        default: ;
      endcase
    end
  end

`ifdef SUB_OVF_EN
  logic ovf_reg;

  // Operands of differing sign, and the result sign differs from the minuend.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
    end else if (state_reg == HIGH) begin
      ovf_reg <= (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]) & (a_reg[WIDTH-1] ^ hi_res[HALF-1]);
    end
  end

  assign ovf = ovf_reg;
`endif

  // Ready is gated by rst_n so it reads low for the whole time reset is held.
  assign in_ready  = rst_n && (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign diff      = diff_reg;
  assign bout      = bout_reg;

endmodule

// File: tb/tb_seq_sub64.sv
// Scoreboard bench for seq_sub64: directed vectors, latency, backpressure and mid-op reset.
module tb_seq_sub64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a, b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] diff;
  logic        bout;
  logic        ovf;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] d;
    logic        bo;
    logic        ov;
  } exp_t;

  exp_t exp_q[$];

  seq_sub64 #(.WIDTH(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
`ifdef SUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

`ifndef SUB_OVF_EN
  assign ovf = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  // Monitor: every accepted result is popped and compared against the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=%h expected=none", diff);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("txn diff=%h bout=%0b ovf=%0b", diff, bout, ovf);
        check("diff", diff, e.d);
        check("bout", {63'd0, bout}, {63'd0, e.bo});
`ifdef SUB_OVF_EN
        check("ovf", {63'd0, ovf}, {63'd0, e.ov});
`endif
      end
    end
  end

  // Called at posedge+#1; returns at posedge+#1 of the accept edge, inputs scrambled.
  task automatic issue(input logic [63:0] ta, input logic [63:0] tb_v, input logic tbin);
    int n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (in_ready !== 1'b1) check("ready_timeout", {63'd0, in_ready}, 64'd1);
    a = ta; b = tb_v; bin = tbin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    bin = ~tbin;
  endtask

  task automatic run_op(input logic [63:0] ta, input logic [63:0] tb_v, input logic tbin,
                        input logic [63:0] ed, input logic ebo, input logic eov);
    exp_t e;
    e.d = ed; e.bo = ebo; e.ov = eov;
    exp_q.push_back(e);
    issue(ta, tb_v, tbin);
    @(posedge clk); #1;
    check("lat_e1_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;
    check("lat_e2_valid", {63'd0, out_valid}, 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_diff", diff, 64'd0);
    check("rst_bout", {63'd0, bout}, 64'd0);
    check("rst_ovf", {63'd0, ovf}, 64'd0);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", {63'd0, in_ready}, 64'd1);

    run_op(64'd5, 64'd3, 1'b0, 64'd2, 1'b0, 1'b0);
    run_op(64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    run_op(64'h0000_0001_0000_0000, 64'd1, 1'b0, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0);
    run_op(64'd0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    run_op(64'h10, 64'h5, 1'b1, 64'hA, 1'b0, 1'b0);
    run_op(64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    run_op(64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_0000_0001, 1'b0,
           64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
           64'h8000_0000_0000_0000, 1'b1, 1'b1);
    run_op(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1,
           64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);

    // Backpressure: result held for 5 cycles while a new request is offered and ignored.
    begin
      exp_t e;
      e.d = 64'd42; e.bo = 1'b0; e.ov = 1'b0;
      exp_q.push_back(e);
    end
    out_ready = 1'b0;
    issue(64'd100, 64'd58, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {63'd0, out_valid}, 64'd1);
      check("bp_diff", diff, 64'd42);
      check("bp_bout", {63'd0, bout}, 64'd0);
      check("bp_in_ready", {63'd0, in_ready}, 64'd0);
      a = 64'd7; b = 64'd1; bin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_idle_ready", {63'd0, in_ready}, 64'd1);
    check("bp_idle_valid", {63'd0, out_valid}, 64'd0);

    // Reset while in HIGH: the in-flight operation is dropped (nothing pushed).
    issue(64'h0000_0000_0000_1234, 64'h34, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_diff", diff, 64'd0);
    check("mid_rst_bout", {63'd0, bout}, 64'd0);
    check("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("mid_rel_in_ready", {63'd0, in_ready}, 64'd1);
    run_op(64'd10, 64'd4, 1'b0, 64'd6, 1'b0, 1'b0);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
